// File: rtl/hrm_pkg.sv
// hrm_pkg: shared types for the memory access sequencer
package hrm_pkg;
  typedef enum logic [2:0] {IDLE, LDA, PW, LDI, DW, WR, FIN} mem_seq_state_t;
endpackage

// File: rtl/mem_seq.sv
// mem_seq: sequences srcA/wAR/wM/mmio strobes for direct and indirect data-memory accesses
module mem_seq
  import hrm_pkg::*;
#(
  parameter int         RD_LAT    = 1,
  parameter logic [7:0] MMIO_BASE = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wr,
  input  logic       indirect,
  input  logic [7:0] addr,
  input  logic [7:0] M,
  output logic       busy,
  output logic       done,
  output logic       srcA,
  output logic       wAR,
  output logic       wM,
  output logic       mmio,
  output logic [7:0] ADDR,
  output logic [7:0] ea
);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
  mem_seq_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_q, wr_d, ind_q, ind_d;
  logic [7:0] addr_q, addr_d, ea_q, ea_d;
  // state, wait counter and latched request; reset drops every strobe at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ind_q   <= 1'b0;
      addr_q  <= '0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      ind_q   <= ind_d;
      addr_q  <= addr_d;
      ea_q    <= ea_d;
    end
  end
  // next state, counter reload on entry to a wait, and Moore strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    ind_d   = ind_q;
    addr_d  = addr_q;
    ea_d    = ea_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LDA;
        wr_d    = wr;
        ind_d   = indirect;
        addr_d  = addr;
        ea_d    = addr;
      end
      LDA: begin
        state_d = ind_q ? PW : (wr_q ? WR : DW);
        cnt_d   = LAT_M1;
      end
      PW: begin
        state_d = cnt_q == 3'd0 ? LDI : PW;
        cnt_d   = cnt_q == 3'd0 ? 3'd0 : cnt_q - 3'd1;
      end
      LDI: begin
        ea_d    = M;
        state_d = wr_q ? WR : DW;
        cnt_d   = LAT_M1;
      end
      DW: begin
        state_d = cnt_q == 3'd0 ? FIN : DW;
        cnt_d   = cnt_q == 3'd0 ? 3'd0 : cnt_q - 3'd1;
      end
      WR:      state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy = state_q != IDLE;
    done = state_q == FIN;
    srcA = state_q == LDI;
    wAR  = state_q == LDA || state_q == LDI;
    wM   = state_q == WR;
    mmio = state_q == WR && ea_q >= MMIO_BASE;
  end
  assign ADDR = addr_q;
  assign ea   = ea_q;
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: scoreboard bench for mem_seq at RD_LAT=1 (inst 0) and RD_LAT=3 (inst 1)
module tb_mem_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start, wr, indirect, busy, done, srcA, wAR, wM, mmio;
  logic [7:0] addr [2];
  logic [7:0] M    [2];
  logic [7:0] ADDR [2];
  logic [7:0] ea   [2];
  logic [7:0] ar   [2];
  logic [7:0] leds [2];
  logic [7:0] rval [2];
  logic [7:0] mem  [2][256];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    int         g;
    int         cy;
    bit         c;
    logic [7:0] m;
    logic [7:0] ea;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int wm_n [2], war_n [2], mmio_n [2], war_cyc [2], wm_cyc [2], mmio_cyc [2];
  logic [7:0] war_src [2];
  logic [7:0] war_addr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : u
    mem_seq #(.RD_LAT(g == 0 ? 1 : 3), .MMIO_BASE(8'hF0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .wr(wr[g]), .indirect(indirect[g]),
      .addr(addr[g]), .M(M[g]), .busy(busy[g]), .done(done[g]), .srcA(srcA[g]),
      .wAR(wAR[g]), .wM(wM[g]), .mmio(mmio[g]), .ADDR(ADDR[g]), .ea(ea[g])
    );
    assign M[g] = mem[g][ar[g]];
  end

  // data memory: AR register, write port, and an LED register for I/O writes
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wAR[g]) ar[g] <= srcA[g] ? M[g] : ADDR[g];
      if (wM[g]) begin
        if (mmio[g]) leds[g] <= rval[g];
        else mem[g][ar[g]] <= rval[g];
      end
    end
  end

  // monitor: strobe invariants, strobe logging, and scoreboard check on done
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wAR[g] | wM[g] | mmio[g]) begin
        tests++;
        if ((wAR[g] & wM[g]) | (mmio[g] & ~wM[g])) begin
          fails++;
          $display("FAIL strobes inst%0d cycle %0d: got wAR=%b wM=%b mmio=%b, required wAR/wM exclusive and mmio only with wM",
                   g, cyc, wAR[g], wM[g], mmio[g]);
        end
      end
      if (wAR[g]) begin
        war_n[g]++;
        war_src[g] = {war_src[g][6:0], srcA[g]};
        war_cyc[g] = cyc;
        if (!srcA[g]) war_addr[g] = ADDR[g];
      end
      if (wM[g]) begin
        wm_n[g]++;
        wm_cyc[g] = cyc;
      end
      if (mmio[g]) begin
        mmio_n[g]++;
        mmio_cyc[g] = cyc;
      end
      if (done[g]) begin
        tests++;
        if (sb.size() == 0 || sb[0].g != g) begin
          fails++;
          $display("FAIL done_unexpected inst%0d cycle %0d: got done=1, required no pending access", g, cyc);
        end else begin
          e_mon = sb.pop_front();
          if (cyc != e_mon.cy || ea[g] !== e_mon.ea || (e_mon.c && M[g] !== e_mon.m)) begin
            fails++;
            $display("FAIL done inst%0d: got cycle %0d ea %h M %h, required cycle %0d ea %h M %h",
                     g, cyc, ea[g], M[g], e_mon.cy, e_mon.ea, e_mon.m);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // present one request for one cycle; lat < 0 means no completion is expected
  task automatic go(input int g, input bit w, input bit ind, input logic [7:0] a, input int lat,
                    input bit c, input logic [7:0] em, input logic [7:0] eea, output int k);
    @(posedge clk);
    #1;
    k = cyc;
    start[g] = 1'b1;
    wr[g] = w;
    indirect[g] = ind;
    addr[g] = a;
    if (lat >= 0) sb.push_back('{g, k + lat, c, em, eea});
    @(posedge clk);
    #1;
    start[g] = 1'b0;
  endtask

  task automatic settle(input int g);
    int i;
    for (i = 0; i < 40 && busy[g]; i++) @(negedge clk);
    chk("busy_timeout", 32'(i < 40), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, b_wm, b_war, b_mmio;
    start = '0;
    wr = '0;
    indirect = '0;
    addr[0] = '0;
    addr[1] = '0;
    rval[0] = '0;
    rval[1] = '0;
    for (int g = 0; g < 2; g++) for (int i = 0; i < 256; i++) mem[g][i] <= 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 32'({busy, done, srcA, wAR, wM, mmio}), 0);
    chk("reset_regs", {ADDR[0], ea[0], ADDR[1], ea[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    mem[0][8'h05] <= 8'h3C;
    b_war = war_n[0];
    b_wm = wm_n[0];
    go(0, 0, 0, 8'h05, 3, 1, 8'h3C, 8'h05, k);
    settle(0);
    chk("rd_war_count", war_n[0] - b_war, 1);
    chk("rd_war_src_addr", {war_src[0][0], war_addr[0]}, {1'b0, 8'h05});
    chk("rd_no_wm", wm_n[0] - b_wm, 0);

    rval[0] = 8'hAA;
    b_wm = wm_n[0];
    b_mmio = mmio_n[0];
    go(0, 1, 0, 8'h10, 3, 1, 8'hAA, 8'h10, k);
    settle(0);
    chk("wr_wm_count", wm_n[0] - b_wm, 1);
    chk("wr_wm_cycle", wm_cyc[0] - k, 2);
    chk("wr_no_mmio", mmio_n[0] - b_mmio, 0);
    chk("wr_mem", mem[0][8'h10], 8'hAA);

    mem[0][8'h02] <= 8'h07;
    mem[0][8'h07] <= 8'h99;
    b_war = war_n[0];
    go(0, 0, 1, 8'h02, 5, 1, 8'h99, 8'h07, k);
    settle(0);
    chk("ird_war_count", war_n[0] - b_war, 2);
    chk("ird_war_src", war_src[0][1:0], 2'b01);
    chk("ird_ldi_cycle", war_cyc[0] - k, 3);

    mem[0][8'h02] <= 8'hF3;
    rval[0] = 8'h5A;
    b_mmio = mmio_n[0];
    go(0, 1, 1, 8'h02, 5, 0, 8'h00, 8'hF3, k);
    settle(0);
    chk("iwr_io_mmio_count", mmio_n[0] - b_mmio, 1);
    chk("iwr_io_cycles", {mmio_cyc[0] - k, wm_cyc[0] - k}, {32'd4, 32'd4});
    chk("iwr_io_leds", leds[0], 8'h5A);
    chk("iwr_io_mem_untouched", mem[0][8'hF3], 8'h00);

    mem[0][8'h02] <= 8'hEF;
    rval[0] = 8'h11;
    b_mmio = mmio_n[0];
    go(0, 1, 1, 8'h02, 5, 0, 8'h00, 8'hEF, k);
    settle(0);
    chk("iwr_ef_no_mmio", mmio_n[0] - b_mmio, 0);
    chk("iwr_ef_mem", mem[0][8'hEF], 8'h11);
    chk("iwr_ef_leds_kept", leds[0], 8'h5A);

    mem[0][8'h02] <= 8'hF0;
    rval[0] = 8'h66;
    b_mmio = mmio_n[0];
    go(0, 1, 1, 8'h02, 5, 0, 8'h00, 8'hF0, k);
    settle(0);
    chk("iwr_f0_mmio", mmio_n[0] - b_mmio, 1);
    chk("iwr_f0_leds", leds[0], 8'h66);

    mem[0][8'h02] <= 8'hFF;
    mem[0][8'hFF] <= 8'h42;
    go(0, 0, 1, 8'h02, 5, 1, 8'h42, 8'hFF, k);
    settle(0);

    mem[0][8'h30] <= 8'h81;
    @(posedge clk);
    #1;
    k = cyc;
    start[0] = 1'b1;
    wr[0] = 1'b0;
    indirect[0] = 1'b0;
    addr[0] = 8'h30;
    sb.push_back('{0, k + 3, 1'b1, 8'h81, 8'h30});
    sb.push_back('{0, k + 7, 1'b1, 8'h81, 8'h30});
    repeat (5) @(posedge clk);
    #1;
    start[0] = 1'b0;
    settle(0);

    mem[1][8'h20] <= 8'h30;
    mem[1][8'h30] <= 8'hC5;
    b_wm = wm_n[1];
    go(1, 0, 1, 8'h20, 9, 1, 8'hC5, 8'h30, k);
    repeat (2) @(posedge clk);
    #1;
    start[1] = 1'b1;
    wr[1] = 1'b1;
    addr[1] = 8'h55;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    settle(1);
    chk("busy_start_ignored_addr", ADDR[1], 8'h20);
    chk("busy_start_no_wm", wm_n[1] - b_wm, 0);

    mem[1][8'h40] <= 8'h90;
    rval[1] = 8'h3E;
    b_wm = wm_n[1];
    go(1, 1, 1, 8'h40, -1, 0, 8'h00, 8'h00, k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_strobes", {busy[1], done[1], srcA[1], wAR[1], wM[1], mmio[1]}, 0);
    chk("rst_ea_addr", {ea[1], ADDR[1]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_wm", wm_n[1] - b_wm, 0);
    chk("rst_no_write", mem[1][8'h90], 8'h00);
    chk("rst_idle", busy[1], 0);

    mem[1][8'h01] <= 8'h77;
    go(1, 0, 0, 8'h01, 5, 1, 8'h77, 8'h01, k);
    settle(1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
